// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//
// Shared definitions for the bit-serial adder:
//   - state_e      : FSM state encoding (IDLE, SHIFT, DONE)
//   - cnt_width()  : bit-counter width for a given operand width
//   - WIDTH_MIN/MAX: legal operand width range
//
// No ports (package).
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits are enough.
  // The guard keeps the width at least 1 if the function is ever called with
  // a degenerate value.
  function automatic int cnt_width(input int width);
    if (width < WIDTH_MIN) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
//
// One-bit combinational full adder: the only arithmetic element of the serial
// adder datapath.
//
// Ports:
//   a, b, cin : input  1  addend bits and carry-in
//   s         : output 1  sum bit
//   co        : output 1  carry-out
// -----------------------------------------------------------------------------
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic p;

  // Propagate term is shared between the sum and carry equations.
  assign p  = a ^ b;
  assign s  = p ^ cin;
  assign co = (a & b) | (cin & p);

endmodule

// File: rtl/bit_serial_adder.sv
// -----------------------------------------------------------------------------
// bit_serial_adder
//
// Adds two WIDTH-bit operands LSB-first, one bit per clock, using a single
// full-adder cell and a carry flip-flop. Result {cout, sum} = a + b + cin.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, a 'sub' port exists; sub=1 at acceptance computes a - b
//   (B register loads ~b, carry loads 1, cin ignored; cout=1 means no borrow).
//   When undefined the block is add-only and the B load path is a plain copy.
//
// Handshake: start is sampled only in IDLE or DONE; the edge that samples it
// high captures a, b, cin (and sub) and begins SHIFT. Starts seen in SHIFT are
// ignored. done pulses for one cycle when sum/cout are valid; sum/cout hold
// until the next accepted start begins overwriting them.
//
// Ports:
//   clk          : input  1      rising-edge clock
//   reset_n      : input  1      asynchronous active-low reset
//   start        : input  1      request
//   a, b         : input  WIDTH  operands
//   cin          : input  1      carry-in
//   sub          : input  1      subtract mode (SERIAL_ADDER_SUB_EN only)
//   busy         : output 1      high while bits are processed
//   done         : output 1      one-cycle result-valid pulse
//   sum          : output WIDTH  result
//   cout         : output 1      final carry-out
//   serial_out   : output 1      current sum bit, LSB first
//   serial_valid : output 1      qualifies serial_out (equals busy)
//   dbg_state    : output 2      FSM state (state_e encoding), for observation
// -----------------------------------------------------------------------------
module bit_serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             serial_out,
  output logic             serial_valid,
  output logic [1:0]       dbg_state
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fa_s;
  logic             fa_co;
  logic             b_load_bit_unused;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // ---------------------------------------------------------------------------
  // The single full-adder cell: always looks at the operand LSBs and carry.
  // ---------------------------------------------------------------------------
  fa_cell u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  // ---------------------------------------------------------------------------
  // Operand-B / carry load values. Subtraction is two's complement: a + ~b + 1.
  // ---------------------------------------------------------------------------
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif
  assign b_load_bit_unused = 1'b0;

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      // IDLE and DONE both accept a new request; DONE falls back to IDLE
      // otherwise, which gives back-to-back operation without a dead cycle.
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        // Sum bits enter at the MSB end so that after WIDTH shifts bit 0 of
        // the operands sits at sum[0].
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_co;
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          cout_d  = fa_co;
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. busy/done are decodes of the state flop. serial_out is gated by
  // busy so that leftover carry in IDLE/DONE never shows on the serial pin.
  // ---------------------------------------------------------------------------
  assign busy         = (state_q == SHIFT);
  assign done         = (state_q == DONE);
  assign sum          = sum_q;
  assign cout         = cout_q;
  assign serial_valid = busy;
  assign serial_out   = busy & fa_s & ~b_load_bit_unused;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_adder
//
// Self-checking bench for bit_serial_adder (WIDTH=8). Expected results come
// from an arithmetic model of {cout, sum} = a + b + cin (or a - b with borrow
// flag when SERIAL_ADDER_SUB_EN is defined) held in an expected queue.
// -----------------------------------------------------------------------------
module tb_bit_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         serial_out;
  logic         serial_valid;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .a            (a),
    .b            (b),
    .cin          (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub          (sub),
`endif
    .busy         (busy),
    .done         (done),
    .sum          (sum),
    .cout         (cout),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int         n_cmp = 0;
  int         n_err = 0;
  logic [W:0] exp_q[$];

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                        input logic mcin, input logic msub);
    logic [W:0] r;
    if (msub) begin
      r = {(ma >= mb), W'(ma - mb)};
    end else begin
      r = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tcin, input logic tsub);
    a   = ta;
    b   = tb_v;
    cin = tcin;
`ifdef SERIAL_ADDER_SUB_EN
    sub = tsub;
`else
    if (tsub) cin = tcin;
`endif
  endtask

  // Presents one request for exactly one edge; returns in the first SHIFT cycle.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tcin, input logic tsub);
    set_ops(ta, tb_v, tcin, tsub);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    set_ops('0, '0, 1'b0, 1'b0);
    #2;
    n_cmp++;
    if ({busy, done, cout, serial_out, serial_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got busy/done/cout/so/sv=%b want 00000",
               {busy, done, cout, serial_out, serial_valid});
    end
    n_cmp++;
    if (sum !== '0) begin
      n_err++;
      $display("FAIL reset_sum: got %h want 00", sum);
    end
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle cyc%0d: got done=%b busy=%b want 0 0", k, done, busy);
      end
    end
    n_cmp++;
    if (dbg_state !== 2'(IDLE)) begin
      n_err++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, 2'(IDLE));
    end
  endtask

  // Directed vectors then random ones; every serial bit and the final result
  // are compared against the model.
  task automatic test_add_random();
    logic [W-1:0] va[4];
    logic [W-1:0] vb[4];
    logic         vc[4];
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    logic [W:0]   ex;
    logic [W:0]   got;
    va = '{8'h5A, 8'hFF, 8'h00, 8'hA5};
    vb = '{8'h33, 8'h01, 8'h00, 8'h5A};
    vc = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int n = 0; n < 28; n++) begin
      if (n < 4) begin
        ra = va[n]; rb = vb[n]; rc = vc[n]; rs = 1'b0;
      end else begin
        ra = W'($urandom_range(0, (1 << W) - 1));
        rb = W'($urandom_range(0, (1 << W) - 1));
        rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
        rs = 1'($urandom_range(0, 1));
`else
        rs = 1'b0;
`endif
      end
      ex = model(ra, rb, rc, rs);
      exp_q.push_back(ex);
      launch(ra, rb, rc, rs);
      for (int i = 0; i < W; i++) begin
        n_cmp++;
        if (busy !== 1'b1 || serial_valid !== 1'b1 || done !== 1'b0) begin
          n_err++;
          $display("FAIL add_shift_flags op%0d bit%0d: got busy=%b sv=%b done=%b want 1 1 0",
                   n, i, busy, serial_valid, done);
        end
        n_cmp++;
        if (serial_out !== ex[i]) begin
          n_err++;
          $display("FAIL add_serial op%0d bit%0d: got %b want %b", n, i, serial_out, ex[i]);
        end
        tick();
      end
      got = exp_q.pop_front();
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0 || serial_valid !== 1'b0) begin
        n_err++;
        $display("FAIL add_done op%0d: got done=%b busy=%b sv=%b want 1 0 0",
                 n, done, busy, serial_valid);
      end
      n_cmp++;
      if ({cout, sum} !== got) begin
        n_err++;
        $display("FAIL add_result op%0d a=%h b=%h cin=%b sub=%b: got %b_%h want %b_%h",
                 n, ra, rb, rc, rs, cout, sum, got[W], got[W-1:0]);
      end
      tick();
      n_cmp++;
      if (done !== 1'b0 || {cout, sum} !== got) begin
        n_err++;
        $display("FAIL add_hold op%0d: got done=%b res=%b_%h want 0 %b_%h",
                 n, done, cout, sum, got[W], got[W-1:0]);
      end
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [W-1:0] sa[2];
    logic [W-1:0] sb[2];
    logic [W:0]   want[2];
    sa   = '{8'h10, 8'h01};
    sb   = '{8'h01, 8'h02};
    want = '{9'h10F, 9'h0FF};
    for (int n = 0; n < 2; n++) begin
      launch(sa[n], sb[n], 1'b0, 1'b1);
      for (int i = 0; i < W; i++) tick();
      n_cmp++;
      if (done !== 1'b1 || {cout, sum} !== want[n]) begin
        n_err++;
        $display("FAIL sub_result%0d: got done=%b %b_%h want 1 %b_%h",
                 n, done, cout, sum, want[n][W], want[n][W-1:0]);
      end
      tick();
    end
  endtask
`endif

  // A start pulse in SHIFT cycle 3 with other operands must change nothing.
  task automatic test_ignored_start();
    logic [W:0] ex;
    int         dones;
    dones = 0;
    ex = model(8'h12, 8'h34, 1'b0, 1'b0);
    exp_q.push_back(ex);
    launch(8'h12, 8'h34, 1'b0, 1'b0);
    for (int k = 0; k < W + 6; k++) begin
      if (k == 3) begin
        set_ops(8'hEE, 8'h77, 1'b1, 1'b0);
        start = 1'b1;
      end
      if (k == 4) start = 1'b0;
      if (done === 1'b1) dones++;
      if (k == W) begin
        ex = exp_q.pop_front();
        n_cmp++;
        if (done !== 1'b1 || {cout, sum} !== ex) begin
          n_err++;
          $display("FAIL ign_result: got done=%b %b_%h want 1 %b_%h",
                   done, cout, sum, ex[W], ex[W-1:0]);
        end
      end
      tick();
    end
    n_cmp++;
    if (dones != 1) begin
      n_err++;
      $display("FAIL ign_done_count: got %0d want 1", dones);
    end
  endtask

  // Reset asserted in SHIFT cycle 4: outputs clear at once, no done afterwards.
  task automatic test_reset_mid_shift();
    int dones;
    int busies;
    dones  = 0;
    busies = 0;
    launch(8'hFF, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, cout, serial_out, serial_valid} !== 5'b0 || sum !== '0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got flags=%b sum=%h want 00000 00",
               {busy, done, cout, serial_out, serial_valid}, sum);
    end
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      if (done === 1'b1) dones++;
      if (busy === 1'b1) busies++;
      tick();
    end
    n_cmp++;
    if (dones != 0 || busies != 0) begin
      n_err++;
      $display("FAIL rst_mid_quiet: got dones=%0d busy_cycles=%0d want 0 0", dones, busies);
    end
    n_cmp++;
    if (dbg_state !== 2'(IDLE)) begin
      n_err++;
      $display("FAIL rst_mid_state: got %0d want %0d", dbg_state, 2'(IDLE));
    end
  endtask

  // start held through DONE: second operation accepted on the DONE edge.
  task automatic test_back_to_back();
    logic [W:0] e1;
    logic [W:0] e2;
    int         dones;
    dones = 0;
    e1 = model(8'h5A, 8'h33, 1'b0, 1'b0);
    e2 = model(8'hC8, 8'h64, 1'b1, 1'b0);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    set_ops(8'h5A, 8'h33, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    set_ops(8'hC8, 8'h64, 1'b1, 1'b0);
    for (int k = 0; k < 2 * W + 4; k++) begin
      if (k == W + 1) start = 1'b0;
      if (done === 1'b1) dones++;
      if (k == W) begin
        e1 = exp_q.pop_front();
        n_cmp++;
        if (done !== 1'b1 || {cout, sum} !== e1) begin
          n_err++;
          $display("FAIL b2b_first: got done=%b %b_%h want 1 %b_%h",
                   done, cout, sum, e1[W], e1[W-1:0]);
        end
      end
      if (k == W + 1) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_restart: got busy=%b want 1", busy);
        end
      end
      if (k == 2 * W + 1) begin
        e2 = exp_q.pop_front();
        n_cmp++;
        if (done !== 1'b1 || {cout, sum} !== e2) begin
          n_err++;
          $display("FAIL b2b_second: got done=%b %b_%h want 1 %b_%h",
                   done, cout, sum, e2[W], e2[W-1:0]);
        end
      end
      tick();
    end
    n_cmp++;
    if (dones != 2) begin
      n_err++;
      $display("FAIL b2b_done_count: got %0d want 2", dones);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_add_random();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_ignored_start();
    test_reset_mid_shift();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
